// File: rtl/ysyx_22041211_mem_pkg.sv
// rtl/ysyx_22041211_mem_pkg.sv - shared types and constants for the memory responder
package ysyx_22041211_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] MEM_BASE_ADDR = 32'h8000_0000;
  localparam int          LANE_BITS     = 8;

  function automatic int lane_count(input int data_len);
    return data_len / LANE_BITS;
  endfunction

endpackage

// File: rtl/ysyx_22041211_sram_array.sv
// rtl/ysyx_22041211_sram_array.sv - word array with byte-lane write enables and registered read
module ysyx_22041211_sram_array
  import ysyx_22041211_mem_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 4096
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic                            re,
  input  logic [$clog2(DEPTH)-1:0]        addr,
  input  logic [DATA_LEN-1:0]             wdata,
  input  logic [DATA_LEN/LANE_BITS-1:0]   wmask,
  output logic [DATA_LEN-1:0]             rdata
);

  logic [DATA_LEN-1:0] mem [DEPTH];

  // rdata only moves on a read, so it stays stable while a response is held
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_LEN / LANE_BITS; i++) begin
        if (wmask[i]) begin
          mem[addr][i*LANE_BITS +: LANE_BITS] <= wdata[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ysyx_22041211_mem_responder.sv
// rtl/ysyx_22041211_mem_responder.sv - single-outstanding memory responder with fixed access latency
module ysyx_22041211_mem_responder
  import ysyx_22041211_mem_pkg::*;
#(
  parameter int          DATA_LEN  = 32,
  parameter int          ADDR_LEN  = 32,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int          LAT       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wen,
  input  logic [ADDR_LEN-1:0]           req_addr,
  input  logic [DATA_LEN-1:0]           req_wdata,
  input  logic [DATA_LEN/LANE_BITS-1:0] req_wmask,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_LEN-1:0]           rsp_rdata,
  output logic                          rsp_err
);

  localparam int                  LANES  = lane_count(DATA_LEN);
  localparam int                  IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_LEN-1:0] BASE   = ADDR_LEN'(BASE_ADDR);
  localparam logic [ADDR_LEN:0]   LIMIT  = (ADDR_LEN+1)'(4 * DEPTH);
  localparam logic [3:0]          LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t state_q, state_d;
  logic [3:0]          cnt_q;
  logic                wen_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [LANES-1:0]    wmask_q;
  logic                rsp_err_q;
  logic                rsp_rd_q;

  logic                accept;
  logic                consume;
  logic                enter_resp;
  logic                acc_wen;
  logic [ADDR_LEN-1:0] acc_addr;
  logic [ADDR_LEN-1:0] acc_off;
  logic [DATA_LEN-1:0] acc_wdata;
  logic [LANES-1:0]    acc_wmask;
  logic                in_range;
  logic                sram_we;
  logic                sram_re;
  logic [DATA_LEN-1:0] sram_rdata;

  assign accept    = (state_q == IDLE) && req_valid;
  assign consume   = (state_q == RESP) && rsp_ready;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? sram_rdata : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (LAT == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LAT=0 the access happens on the accept edge itself, before the latches hold the request
  always_comb begin
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (state_q == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
    acc_off    = acc_addr - BASE;
    in_range   = (acc_addr >= BASE) && ({1'b0, acc_off} < LIMIT);
    enter_resp = (state_d == RESP) && (state_q != RESP) && !rst;
    sram_we    = enter_resp && acc_wen && in_range;
    sram_re    = enter_resp && !acc_wen && in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= LAT_M1;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        rsp_err_q <= !in_range;
        rsp_rd_q  <= !acc_wen && in_range;
      end else if (consume) begin
        rsp_err_q <= 1'b0;
        rsp_rd_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  ysyx_22041211_sram_array #(
    .DATA_LEN (DATA_LEN),
    .DEPTH    (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .re    (sram_re),
    .addr  (acc_off[IDX_W+1:2]),
    .wdata (acc_wdata),
    .wmask (acc_wmask),
    .rdata (sram_rdata)
  );

endmodule
